signal_limit_monitor: RTL and testbench
=======================================

// Module: signal_limit_monitor
// PURPOSE
//  Observes the unclamped signal ahead of the DAC clamp and reports limit violations.
//  Debounces excursions above/below limits, applies exit hysteresis, counts events and
//  raises a sticky alarm for the PS-side register bank. Pure observer: never alters the signal.
// PARAMETERS
//  WIDTH      16  signed sample/limit width
//  CNT_WIDTH  32  event counter width (saturating)
//  DUR_WIDTH  16  debounce/run-length counter width
// PORTS
//  clk              in   1          system clock
//  reset            in   1          synchronous, active-high reset
//  signal_in        in   WIDTH      signed sample, one per clk
//  limit_upper      in   WIDTH      signed upper limit
//  limit_lower      in   WIDTH      signed lower limit
//  hysteresis       in   WIDTH-1    unsigned exit margin
//  min_cycles       in   DUR_WIDTH  consecutive violating samples before event (0 treated as 1)
//  alarm_ack        in   1          one-cycle pulse, clears alarm
//  counter_clear    in   1          one-cycle pulse, zeroes counters (and peaks)
//  over_active      out  1          FSM in OVER
//  under_active     out  1          FSM in UNDER
//  alarm            out  1          sticky, set on any event
//  config_error     out  1          limit_lower > limit_upper
//  over_count       out  CNT_WIDTH  OVER entries
//  under_count      out  CNT_WIDTH  UNDER entries
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IN_RANGE, run counter 0, pipeline regs 0.
//  - Stage 1: signal_in and limits registered at edge N+1; compares use registered copies.
//  - Stage 2: FSM and outputs update at edge N+2. Fixed 2-cycle latency sample -> flags.
//  - Exit thresholds computed at WIDTH+1 bits: upper-hyst, lower+hyst; no wrap.
//  - States: IN_RANGE, PEND_OVER, OVER, PEND_UNDER, UNDER.
//  - IN_RANGE: s>upper -> PEND_OVER, run=1 (straight to OVER if min_cycles<=1); s<lower analog.
//  - PEND_OVER: s>upper -> run++; run+1==min_cycles -> OVER. Else -> IN_RANGE, run=0.
//  - OVER: s<=upper-hyst -> IN_RANGE. s<lower -> PEND_UNDER/UNDER as from IN_RANGE.
//  - PEND_UNDER/UNDER mirror the above with lower, lower+hyst.
//  - Event = entry into OVER/UNDER: matching count +1, saturating at all-ones; alarm<=1.
//  - alarm_ack with event in same cycle: alarm stays 1 (set wins).
//  - counter_clear with event in same cycle: count ends 0 (clear wins).
//  - config_error registered from stage-1 limits; while 1, FSM held IN_RANGE, no events, run=0.
//    Counters and alarm keep their values.
//  - Limits changing mid-excursion: next compare uses new values, no special handling.
//  - Reset mid-excursion: immediate return to reset values, no event emitted.
// CONFIGURATION
//  - SIGNAL_LIMIT_MONITOR_PEAK_EN defined adds outputs peak_over, peak_under (WIDTH, signed):
//    max/min registered sample seen in PEND_OVER|OVER / PEND_UNDER|UNDER.
//    Reset: peak_over=-2^(WIDTH-1), peak_under=2^(WIDTH-1)-1. counter_clear restores these.
//  - Undefined: ports and logic absent, all other behaviour identical.
// STRUCTURE
//  - Shared package signal_limit_pkg:
//    FSM state localparams (3-bit encoding), default WIDTH, saturating-increment function.
//  - Sub-module limit_compare: stage-1 registers, widened hysteresis thresholds;
//    emits above/below/exit_over/exit_under/config_error flags.
//  - Top: FSM, run counter, event counters, alarm, optional peak logic.
// TESTING
//  - upper=1000, lower=-1000, hyst=100, min=3; 2 samples 1200 then 0
//    -> no event, over_count=0.
//  - same, 3 samples 1200 -> over_active 1 two clks after 3rd sample, over_count=1, alarm=1.
//    950 keeps OVER; 900 -> over_active 0.
//  - In OVER, jump to -1500 with min=1 -> under_active=1, over_active=0, under_count=1.
//  - alarm_ack and new event in same cycle -> alarm=1.
//    counter_clear and event in same cycle -> count=0.
//  - lower=500, upper=-500 -> config_error=1, 30000 input gives no event.
//    Restore limits -> config_error=0 two clks later.
//  - CNT_WIDTH=4, 20 events -> count saturates at 15.
//    reset mid-PEND_OVER -> all outputs 0 next clk.

Source files
------------

// File: rtl/signal_limit_pkg.sv
// Shared definitions for signal_limit_monitor: FSM state encoding, default widths and
// a saturating increment used by the event counters.
package signal_limit_pkg;

   localparam int DEFAULT_WIDTH     = 16;
   localparam int DEFAULT_CNT_WIDTH = 32;
   localparam int DEFAULT_DUR_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IN_RANGE   = 3'd0,
      ST_PEND_OVER  = 3'd1,
      ST_OVER       = 3'd2,
      ST_PEND_UNDER = 3'd3,
      ST_UNDER      = 3'd4
   } limit_state_e;

   // Increment that sticks at the all-ones value of a width-bit counter.
   function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
      logic [63:0] max_val;
      max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
      return (value >= max_val) ? max_val : value + 64'd1;
   endfunction

endpackage

// File: rtl/limit_compare.sv
// Stage-1 pipeline: registers sample, limits and hysteresis, then derives the compare flags.
// With SIGNAL_LIMIT_MONITOR_PEAK_EN defined it also exposes the registered sample.
module limit_compare
   import signal_limit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] signal_i,
   input  logic signed [WIDTH-1:0] upper_i,
   input  logic signed [WIDTH-1:0] lower_i,
   input  logic        [WIDTH-2:0] hyst_i,
`ifdef SIGNAL_LIMIT_MONITOR_PEAK_EN
   output logic signed [WIDTH-1:0] sample_o,
`endif
   output logic                    above_o,
   output logic                    below_o,
   output logic                    exit_over_o,
   output logic                    exit_under_o,
   output logic                    config_error_o
);

   logic signed [WIDTH-1:0] sample_q;
   logic signed [WIDTH-1:0] upper_q;
   logic signed [WIDTH-1:0] lower_q;
   logic        [WIDTH-2:0] hyst_q;
   logic signed [WIDTH:0]   sample_wide;
   logic signed [WIDTH:0]   hyst_wide;
   logic signed [WIDTH:0]   exit_over_thr;
   logic signed [WIDTH:0]   exit_under_thr;

   always_ff @(posedge clk) begin
      if (reset) begin
         sample_q <= '0;
         upper_q  <= '0;
         lower_q  <= '0;
         hyst_q   <= '0;
      end else begin
         sample_q <= signal_i;
         upper_q  <= upper_i;
         lower_q  <= lower_i;
         hyst_q   <= hyst_i;
      end
   end

   // One extra bit so limits near full scale minus/plus hysteresis cannot wrap.
   assign sample_wide    = {sample_q[WIDTH-1], sample_q};
   assign hyst_wide      = {2'b00, hyst_q};
   assign exit_over_thr  = {upper_q[WIDTH-1], upper_q} - hyst_wide;
   assign exit_under_thr = {lower_q[WIDTH-1], lower_q} + hyst_wide;

   assign above_o        = sample_q > upper_q;
   assign below_o        = sample_q < lower_q;
   assign exit_over_o    = sample_wide <= exit_over_thr;
   assign exit_under_o   = sample_wide >= exit_under_thr;
   assign config_error_o = lower_q > upper_q;

`ifdef SIGNAL_LIMIT_MONITOR_PEAK_EN
   assign sample_o = sample_q;
`endif

endmodule

// File: rtl/signal_limit_monitor.sv
// Limit monitor top: debounce FSM, run counter, saturating event counters and sticky alarm.
// Optional peak tracking outputs are enabled by defining SIGNAL_LIMIT_MONITOR_PEAK_EN.
module signal_limit_monitor
   import signal_limit_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
   parameter int DUR_WIDTH = DEFAULT_DUR_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] signal_in,
   input  logic signed [WIDTH-1:0] limit_upper,
   input  logic signed [WIDTH-1:0] limit_lower,
   input  logic        [WIDTH-2:0] hysteresis,
   input  logic [DUR_WIDTH-1:0]    min_cycles,
   input  logic                    alarm_ack,
   input  logic                    counter_clear,
   output logic                    over_active,
   output logic                    under_active,
   output logic                    alarm,
   output logic                    config_error,
   output logic [CNT_WIDTH-1:0]    over_count,
   output logic [CNT_WIDTH-1:0]    under_count
`ifdef SIGNAL_LIMIT_MONITOR_PEAK_EN
   ,
   output logic signed [WIDTH-1:0] peak_over,
   output logic signed [WIDTH-1:0] peak_under
`endif
);

   logic above, below, exit_over, exit_under, cfg_err;
   limit_state_e state_q, state_d;
   logic [DUR_WIDTH-1:0] run_q, run_d, min_eff;
   logic [DUR_WIDTH:0]   run_inc;
   logic [CNT_WIDTH-1:0] over_cnt_q, under_cnt_q, over_cnt_d, under_cnt_d;
   logic over_active_q, under_active_q, alarm_q, cfg_q;
   logic ev_over, ev_under, single_shot;
   limit_state_e start_over_st, start_under_st;
   logic [DUR_WIDTH-1:0] start_run;
`ifdef SIGNAL_LIMIT_MONITOR_PEAK_EN
   logic signed [WIDTH-1:0] sample;
`endif

   limit_compare #(.WIDTH(WIDTH)) u_compare (
      .clk            (clk),
      .reset          (reset),
      .signal_i       (signal_in),
      .upper_i        (limit_upper),
      .lower_i        (limit_lower),
      .hyst_i         (hysteresis),
`ifdef SIGNAL_LIMIT_MONITOR_PEAK_EN
      .sample_o       (sample),
`endif
      .above_o        (above),
      .below_o        (below),
      .exit_over_o    (exit_over),
      .exit_under_o   (exit_under),
      .config_error_o (cfg_err)
   );

   always_comb begin
      min_eff        = (min_cycles == '0) ? DUR_WIDTH'(1) : min_cycles;
      run_inc        = {1'b0, run_q} + 1'b1;
      single_shot    = (min_eff == DUR_WIDTH'(1));
      start_over_st  = single_shot ? ST_OVER  : ST_PEND_OVER;
      start_under_st = single_shot ? ST_UNDER : ST_PEND_UNDER;
      start_run      = single_shot ? '0 : DUR_WIDTH'(1);
      state_d        = state_q;
      run_d          = run_q;
      if (cfg_err) begin
         state_d = ST_IN_RANGE;
         run_d   = '0;
      end else begin
         unique case (state_q)
            ST_IN_RANGE: begin
               if (above) begin
                  state_d = start_over_st;  run_d = start_run;
               end else if (below) begin
                  state_d = start_under_st; run_d = start_run;
               end
            end
            ST_PEND_OVER: begin
               if (!above) begin
                  state_d = ST_IN_RANGE; run_d = '0;
               end else if (run_inc == {1'b0, min_eff}) begin
                  state_d = ST_OVER;     run_d = '0;
               end else begin
                  run_d = run_inc[DUR_WIDTH-1:0];
               end
            end
            ST_PEND_UNDER: begin
               if (!below) begin
                  state_d = ST_IN_RANGE; run_d = '0;
               end else if (run_inc == {1'b0, min_eff}) begin
                  state_d = ST_UNDER;    run_d = '0;
               end else begin
                  run_d = run_inc[DUR_WIDTH-1:0];
               end
            end
            ST_OVER: begin
               if (below) begin
                  state_d = start_under_st; run_d = start_run;
               end else if (exit_over) begin
                  state_d = ST_IN_RANGE;
               end
            end
            ST_UNDER: begin
               if (above) begin
                  state_d = start_over_st; run_d = start_run;
               end else if (exit_under) begin
                  state_d = ST_IN_RANGE;
               end
            end
            default: begin
               state_d = ST_IN_RANGE; run_d = '0;
            end
         endcase
      end
      // An event is any fresh entry into OVER or UNDER.
      ev_over     = (state_d == ST_OVER)  && (state_q != ST_OVER);
      ev_under    = (state_d == ST_UNDER) && (state_q != ST_UNDER);
      over_cnt_d  = CNT_WIDTH'(sat_inc(64'(over_cnt_q),  CNT_WIDTH));
      under_cnt_d = CNT_WIDTH'(sat_inc(64'(under_cnt_q), CNT_WIDTH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IN_RANGE;
         run_q          <= '0;
         over_cnt_q     <= '0;
         under_cnt_q    <= '0;
         over_active_q  <= 1'b0;
         under_active_q <= 1'b0;
         alarm_q        <= 1'b0;
         cfg_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         run_q          <= run_d;
         over_active_q  <= (state_d == ST_OVER);
         under_active_q <= (state_d == ST_UNDER);
         cfg_q          <= cfg_err;
         if (counter_clear)   over_cnt_q  <= '0;
         else if (ev_over)    over_cnt_q  <= over_cnt_d;
         if (counter_clear)   under_cnt_q <= '0;
         else if (ev_under)   under_cnt_q <= under_cnt_d;
         if (ev_over || ev_under) alarm_q <= 1'b1;
         else if (alarm_ack)      alarm_q <= 1'b0;
      end
   end

   assign over_active  = over_active_q;
   assign under_active = under_active_q;
   assign alarm        = alarm_q;
   assign config_error = cfg_q;
   assign over_count   = over_cnt_q;
   assign under_count  = under_cnt_q;

`ifdef SIGNAL_LIMIT_MONITOR_PEAK_EN
   localparam logic signed [WIDTH-1:0] PEAK_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] PEAK_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   logic signed [WIDTH-1:0] peak_over_q, peak_under_q;

   always_ff @(posedge clk) begin
      if (reset || counter_clear) begin
         peak_over_q  <= PEAK_MIN;
         peak_under_q <= PEAK_MAX;
      end else begin
         if ((state_d == ST_PEND_OVER || state_d == ST_OVER) && sample > peak_over_q)
            peak_over_q <= sample;
         if ((state_d == ST_PEND_UNDER || state_d == ST_UNDER) && sample < peak_under_q)
            peak_under_q <= sample;
      end
   end

   assign peak_over  = peak_over_q;
   assign peak_under = peak_under_q;
`endif

endmodule

// File: tb/tb_signal_limit_monitor.sv
// Self-checking bench for signal_limit_monitor: directed scenarios plus randomized traffic
// compared against an excursion-level reference model.
module tb_signal_limit_monitor;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic signed [15:0] signal_in = '0;
   logic signed [15:0] limit_upper = '0;
   logic signed [15:0] limit_lower = '0;
   logic [14:0] hysteresis = '0;
   logic [15:0] min_cycles = 16'd1;
   logic alarm_ack = 1'b0;
   logic counter_clear = 1'b0;

   logic over_active, under_active, alarm, config_error;
   logic [31:0] over_count, under_count;
   logic over_active_s, under_active_s, alarm_s, config_error_s;
   logic [3:0] over_count_s, under_count_s;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: stage-1 copy plus excursion bookkeeping.
   int m_sig, m_up, m_lo, m_hy;
   int m_mode;   // +1 over, -1 under, 0 in range
   int m_pend;   // direction of pending excursion, 0 if none
   int m_run;
   bit m_alarm, m_cfg;
   longint m_oc, m_uc;
   int m_oc4, m_uc4;

   signal_limit_monitor dut (
      .clk(clk), .reset(reset), .signal_in(signal_in), .limit_upper(limit_upper),
      .limit_lower(limit_lower), .hysteresis(hysteresis), .min_cycles(min_cycles),
      .alarm_ack(alarm_ack), .counter_clear(counter_clear),
      .over_active(over_active), .under_active(under_active), .alarm(alarm),
      .config_error(config_error), .over_count(over_count), .under_count(under_count)
   );

   signal_limit_monitor #(.CNT_WIDTH(4)) dut_small (
      .clk(clk), .reset(reset), .signal_in(signal_in), .limit_upper(limit_upper),
      .limit_lower(limit_lower), .hysteresis(hysteresis), .min_cycles(min_cycles),
      .alarm_ack(alarm_ack), .counter_clear(counter_clear),
      .over_active(over_active_s), .under_active(under_active_s), .alarm(alarm_s),
      .config_error(config_error_s), .over_count(over_count_s), .under_count(under_count_s)
   );

   always #5 clk = ~clk;

   task automatic start_exc(input int dir, input int mc, output int ev);
      m_mode = 0;
      m_pend = 0;
      if (mc <= 1) begin
         m_mode = dir; m_run = 0; ev = dir;
      end else begin
         m_pend = dir; m_run = 1; ev = 0;
      end
   endtask

   task automatic model_edge();
      int mc, ev;
      bit above, below;
      if (reset) begin
         m_sig = 0; m_up = 0; m_lo = 0; m_hy = 0;
         m_mode = 0; m_pend = 0; m_run = 0; m_alarm = 0; m_cfg = 0;
         m_oc = 0; m_uc = 0; m_oc4 = 0; m_uc4 = 0;
         return;
      end
      mc = (min_cycles == 16'd0) ? 1 : int'(min_cycles);
      ev = 0;
      m_cfg = (m_lo > m_up);
      if (m_cfg) begin
         m_mode = 0; m_pend = 0; m_run = 0;
      end else begin
         above = (m_sig > m_up);
         below = (m_sig < m_lo);
         if (m_mode == 1) begin
            if (below) start_exc(-1, mc, ev);
            else if (m_sig <= m_up - m_hy) m_mode = 0;
         end else if (m_mode == -1) begin
            if (above) start_exc(1, mc, ev);
            else if (m_sig >= m_lo + m_hy) m_mode = 0;
         end else if (m_pend != 0) begin
            if ((m_pend == 1 && above) || (m_pend == -1 && below)) begin
               m_run++;
               if (m_run == mc) begin
                  m_mode = m_pend; ev = m_pend; m_pend = 0; m_run = 0;
               end
            end else begin
               m_pend = 0; m_run = 0;
            end
         end else if (above) begin
            start_exc(1, mc, ev);
         end else if (below) begin
            start_exc(-1, mc, ev);
         end
      end
      if (ev == 1) begin
         if (m_oc < 64'd4294967295) m_oc++;
         if (m_oc4 < 15) m_oc4++;
      end else if (ev == -1) begin
         if (m_uc < 64'd4294967295) m_uc++;
         if (m_uc4 < 15) m_uc4++;
      end
      if (ev != 0) m_alarm = 1;
      else if (alarm_ack) m_alarm = 0;
      if (counter_clear) begin
         m_oc = 0; m_uc = 0; m_oc4 = 0; m_uc4 = 0;
      end
      m_sig = int'(signal_in);
      m_up  = int'(limit_upper);
      m_lo  = int'(limit_lower);
      m_hy  = int'(hysteresis);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      tests_run++;
      if ({over_active, under_active, alarm, config_error} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {over_active, under_active, alarm, config_error});
      end
      tests_run++;
      if (over_count !== 32'd0 || under_count !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_counts: got over=%0d under=%0d expected 0 0", over_count, under_count);
      end
      $display("[TB] reset: flags=%b counts=%0d/%0d",
               {over_active, under_active, alarm, config_error}, over_count, under_count);
   endtask

   task automatic test_debounce();
      limit_upper = 16'sd1000; limit_lower = -16'sd1000; hysteresis = 15'd100; min_cycles = 16'd3;
      signal_in = 16'sd1200;
      cycle(); cycle();
      signal_in = 16'sd0;
      repeat (4) cycle();
      tests_run++;
      if (over_count !== 32'd0 || over_active !== 1'b0 || alarm !== 1'b0) begin
         tests_failed++;
         $display("FAIL short_excursion: got count=%0d active=%b alarm=%b expected 0 0 0",
                  over_count, over_active, alarm);
      end
      signal_in = 16'sd1200;
      repeat (3) cycle();
      tests_run++;
      if (over_active !== 1'b0) begin
         tests_failed++;
         $display("FAIL over_latency_early: got %b expected 0", over_active);
      end
      signal_in = 16'sd950;
      cycle();
      tests_run++;
      if (over_active !== 1'b1 || over_count !== 32'd1 || alarm !== 1'b1) begin
         tests_failed++;
         $display("FAIL over_entry: got active=%b count=%0d alarm=%b expected 1 1 1",
                  over_active, over_count, alarm);
      end
      cycle();
      signal_in = 16'sd900;
      cycle();
      tests_run++;
      if (over_active !== 1'b1) begin
         tests_failed++;
         $display("FAIL hysteresis_hold: got %b expected 1", over_active);
      end
      cycle();
      tests_run++;
      if (over_active !== 1'b0) begin
         tests_failed++;
         $display("FAIL hysteresis_exit: got %b expected 0", over_active);
      end
      $display("[TB] debounce: over_count=%0d over_active=%b", over_count, over_active);
   endtask

   task automatic test_swing();
      min_cycles = 16'd1;
      signal_in = 16'sd1200;
      cycle(); cycle();
      tests_run++;
      if (over_active !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_cycle_over: got %b expected 1", over_active);
      end
      signal_in = -16'sd1500;
      cycle(); cycle();
      tests_run++;
      if (under_active !== 1'b1 || over_active !== 1'b0 || under_count !== 32'd1
          || over_count !== 32'd2) begin
         tests_failed++;
         $display("FAIL over_to_under: got u=%b o=%b uc=%0d oc=%0d expected 1 0 1 2",
                  under_active, over_active, under_count, over_count);
      end
      $display("[TB] swing: under_active=%b under_count=%0d", under_active, under_count);
   endtask

   task automatic test_ack_clear();
      signal_in = 16'sd0;
      cycle(); cycle();
      alarm_ack = 1'b1;
      cycle();
      alarm_ack = 1'b0;
      tests_run++;
      if (alarm !== 1'b0) begin
         tests_failed++;
         $display("FAIL alarm_ack: got %b expected 0", alarm);
      end
      signal_in = 16'sd1200;
      cycle();
      alarm_ack = 1'b1;
      cycle();
      alarm_ack = 1'b0;
      tests_run++;
      if (alarm !== 1'b1 || over_active !== 1'b1 || over_count !== 32'd3) begin
         tests_failed++;
         $display("FAIL ack_vs_event: got alarm=%b active=%b count=%0d expected 1 1 3",
                  alarm, over_active, over_count);
      end
      signal_in = 16'sd0;
      cycle(); cycle();
      signal_in = -16'sd1500;
      cycle();
      counter_clear = 1'b1;
      cycle();
      counter_clear = 1'b0;
      tests_run++;
      if (under_active !== 1'b1 || under_count !== 32'd0 || over_count !== 32'd0
          || under_count_s !== 4'd0) begin
         tests_failed++;
         $display("FAIL clear_vs_event: got u=%b uc=%0d oc=%0d uc4=%0d expected 1 0 0 0",
                  under_active, under_count, over_count, under_count_s);
      end
      $display("[TB] ack/clear: alarm=%b under_count=%0d", alarm, under_count);
   endtask

   task automatic test_config_error();
      limit_lower = 16'sd500; limit_upper = -16'sd500;
      signal_in = 16'sd30000;
      cycle();
      tests_run++;
      if (config_error !== 1'b0) begin
         tests_failed++;
         $display("FAIL cfg_latency_early: got %b expected 0", config_error);
      end
      cycle();
      tests_run++;
      if (config_error !== 1'b1 || under_active !== 1'b0) begin
         tests_failed++;
         $display("FAIL cfg_set: got cfg=%b under=%b expected 1 0", config_error, under_active);
      end
      repeat (4) cycle();
      tests_run++;
      if (over_active !== 1'b0 || under_active !== 1'b0 || over_count !== 32'd0 || alarm !== 1'b1) begin
         tests_failed++;
         $display("FAIL cfg_hold: got o=%b u=%b oc=%0d alarm=%b expected 0 0 0 1",
                  over_active, under_active, over_count, alarm);
      end
      limit_upper = 16'sd1000; limit_lower = -16'sd1000;
      signal_in = 16'sd0;
      cycle();
      tests_run++;
      if (config_error !== 1'b1) begin
         tests_failed++;
         $display("FAIL cfg_restore_early: got %b expected 1", config_error);
      end
      cycle();
      tests_run++;
      if (config_error !== 1'b0) begin
         tests_failed++;
         $display("FAIL cfg_restore: got %b expected 0", config_error);
      end
      $display("[TB] config_error: cfg=%b over_count=%0d", config_error, over_count);
   endtask

   task automatic test_saturation();
      counter_clear = 1'b1;
      signal_in = 16'sd0;
      cycle();
      counter_clear = 1'b0;
      min_cycles = 16'd1;
      for (int i = 0; i < 20; i++) begin
         signal_in = 16'sd1200;
         cycle();
         signal_in = 16'sd0;
         cycle();
      end
      cycle(); cycle();
      tests_run++;
      if (over_count_s !== 4'd15 || over_count !== 32'd20) begin
         tests_failed++;
         $display("FAIL saturation: got small=%0d wide=%0d expected 15 20", over_count_s, over_count);
      end
      $display("[TB] saturation: small=%0d wide=%0d", over_count_s, over_count);
   endtask

   task automatic test_reset_mid();
      min_cycles = 16'd5;
      signal_in = 16'sd1200;
      repeat (3) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      tests_run++;
      if ({over_active, under_active, alarm, config_error} !== 4'b0000 || over_count !== 32'd0
          || over_count_s !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_mid: got flags=%b oc=%0d oc4=%0d expected 0000 0 0",
                  {over_active, under_active, alarm, config_error}, over_count, over_count_s);
      end
      repeat (4) cycle();
      signal_in = 16'sd0;
      cycle(); cycle();
      tests_run++;
      if (over_count !== 32'd0 || over_active !== 1'b0) begin
         tests_failed++;
         $display("FAIL run_cleared: got oc=%0d active=%b expected 0 0", over_count, over_active);
      end
      $display("[TB] reset mid-excursion: over_count=%0d", over_count);
   endtask

   task automatic test_random();
      int up, lo, sel;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
               up = -32600; lo = -32768;
            end else if (sel == 1) begin
               up = 32767; lo = 32600;
            end else begin
               up = int'($urandom_range(0, 3000)) - 1000;
               lo = (sel == 2) ? up + int'($urandom_range(1, 500))
                               : up - int'($urandom_range(0, 2500));
            end
            limit_upper = 16'(up);
            limit_lower = 16'(lo);
            hysteresis  = 15'($urandom_range(0, 400));
            min_cycles  = 16'($urandom_range(0, 4));
         end
         sel = int'($urandom_range(0, 4));
         case (sel)
            0: signal_in = 16'($urandom);
            1: signal_in = 16'(int'(limit_upper) + int'($urandom_range(0, 600)) - 300);
            2: signal_in = 16'(int'(limit_lower) + int'($urandom_range(0, 600)) - 300);
            default: signal_in = 16'(int'($urandom_range(0, 8000)) - 4000);
         endcase
         alarm_ack     = ($urandom_range(0, 19) == 0);
         counter_clear = ($urandom_range(0, 149) == 0);
         reset         = ($urandom_range(0, 499) == 0);
         cycle();
         tests_run++;
         if (over_active !== (m_mode == 1) || under_active !== (m_mode == -1)
             || alarm !== m_alarm || config_error !== m_cfg
             || over_count !== m_oc[31:0] || under_count !== m_uc[31:0]
             || over_count_s !== 4'(m_oc4) || under_count_s !== 4'(m_uc4)) begin
            tests_failed++;
            $display("FAIL random[%0d]: got o=%b u=%b a=%b c=%b oc=%0d uc=%0d oc4=%0d uc4=%0d expected o=%0d u=%0d a=%b c=%b oc=%0d uc=%0d oc4=%0d uc4=%0d",
                     i, over_active, under_active, alarm, config_error, over_count, under_count,
                     over_count_s, under_count_s, (m_mode == 1), (m_mode == -1), m_alarm, m_cfg,
                     m_oc, m_uc, m_oc4, m_uc4);
         end
      end
      alarm_ack = 1'b0;
      counter_clear = 1'b0;
      reset = 1'b0;
      $display("[TB] random: %0d cycles, over_count=%0d under_count=%0d", 3000, over_count, under_count);
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_swing();
      test_ack_clear();
      test_config_error();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
